sram_arbiter: RTL

Shares the single external 8-bit SRAM between three requesters: the video fetch path (CRTC/GA pixel reads), the Z80 memory path (reads/writes), and the host boot loader (32-bit ROM-image words written as four bytes). It sits between the CPC memory decoder and the SRAM pins, runs on the 16 MHz system clock, and serialises all accesses through a fixed four-cycle slot with strict priority video > CPU > boot.

---
 rtl/sram_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - fixed-priority four-cycle slot arbiter for the shared 8-bit SRAM
// Video > CPU > boot; a boot word in progress locks out the CPU until its fourth byte lands.
module sram_arbiter #(
  parameter int ADDR_W = 21
) (
  input  logic              ck16,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  input  logic              boot_req,
  input  logic [ADDR_W-1:0] boot_addr,
  input  logic [31:0]       boot_data,
  output logic              boot_ack,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  output logic              sram_oe,
  input  logic [7:0]        sram_din,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {IDLE, P0, P1, DONE} state_t;
  typedef enum logic [1:0] {OWN_VID, OWN_CPU, OWN_BOOT} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                we_q, we_d;
  logic [1:0]          k_q, k_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [7:0]          sram_dout_q, sram_dout_d;
  logic                sram_oe_q, sram_oe_d;
  logic                sram_we_n_q, sram_we_n_d;
  logic [7:0]          vid_data_q, vid_data_d;
  logic [7:0]          cpu_rdata_q, cpu_rdata_d;
  logic                vid_valid_q, vid_valid_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                boot_ack_q, boot_ack_d;
  logic [7:0]          boot_byte;

  assign boot_byte = boot_data[{k_q, 3'b000} +: 8];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    k_d         = k_q;
    sram_addr_d = sram_addr_q;
    sram_dout_d = sram_dout_q;
    sram_oe_d   = sram_oe_q;
    sram_we_n_d = 1'b1;
    vid_data_d  = vid_data_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_valid_d = 1'b0;
    cpu_ack_d   = 1'b0;
    boot_ack_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vid_req) begin
          state_d     = P0;
          owner_d     = OWN_VID;
          we_d        = 1'b0;
          sram_addr_d = vid_addr;
        end else if (cpu_req && (k_q == 2'd0)) begin
          state_d     = P0;
          owner_d     = OWN_CPU;
          we_d        = cpu_we;
          sram_addr_d = cpu_addr;
          sram_dout_d = cpu_wdata;
        end else if (boot_req) begin
          state_d     = P0;
          owner_d     = OWN_BOOT;
          we_d        = 1'b1;
          sram_addr_d = boot_addr + ADDR_W'(k_q);
          sram_dout_d = boot_byte;
        end
        sram_oe_d = (state_d == P0) && we_d;
      end
      P0: begin
        state_d     = P1;
        sram_oe_d   = we_q;
        sram_we_n_d = ~we_q;
      end
      P1: begin
        // sram_din is sampled only on the P1 -> DONE edge
        state_d   = DONE;
        sram_oe_d = 1'b0;
        case (owner_q)
          OWN_VID: begin
            vid_data_d  = sram_din;
            vid_valid_d = 1'b1;
          end
          OWN_CPU: begin
            if (!we_q) cpu_rdata_d = sram_din;
            cpu_ack_d = 1'b1;
          end
          default: begin
            if (k_q == 2'd3) boot_ack_d = 1'b1;
            k_d = k_q + 2'd1;
          end
        endcase
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck16) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_VID;
      we_q        <= 1'b0;
      k_q         <= 2'd0;
      sram_addr_q <= '0;
      sram_dout_q <= 8'd0;
      sram_oe_q   <= 1'b0;
      sram_we_n_q <= 1'b1;
      vid_data_q  <= 8'd0;
      cpu_rdata_q <= 8'd0;
      vid_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      boot_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      k_q         <= k_d;
      sram_addr_q <= sram_addr_d;
      sram_dout_q <= sram_dout_d;
      sram_oe_q   <= sram_oe_d;
      sram_we_n_q <= sram_we_n_d;
      vid_data_q  <= vid_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_valid_q <= vid_valid_d;
      cpu_ack_q   <= cpu_ack_d;
      boot_ack_q  <= boot_ack_d;
    end
  end

  assign sram_addr = sram_addr_q;
  assign sram_dout = sram_dout_q;
  assign sram_oe   = sram_oe_q;
  assign sram_we_n = sram_we_n_q;
  assign vid_data  = vid_data_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_valid = vid_valid_q;
  assign cpu_ack   = cpu_ack_q;
  assign boot_ack  = boot_ack_q;

endmodule
